// File: rtl/line_burst_arbiter.sv
// Round-robin arbiter that turns whole-line cache requests into word bursts
// to main memory, collecting read words back into a line.
module line_burst_arbiter #(
    parameter int NUM_PORTS    = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int OFFSET_BITS  = 2,
    localparam int WORDS  = 1 << OFFSET_BITS,
    localparam int LINE_W = DATA_WIDTH * WORDS
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           req_valid,
    output logic [NUM_PORTS-1:0]           req_ready,
    input  logic [NUM_PORTS-1:0]           req_write,
    input  logic [NUM_PORTS*ADDRESS_BITS-1:0] req_address,
    input  logic [NUM_PORTS*LINE_W-1:0]    req_data,
    output logic [NUM_PORTS-1:0]           rsp_valid,
    output logic [ADDRESS_BITS-1:0]        rsp_address,
    output logic [LINE_W-1:0]              rsp_data,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic                           mem_req_write,
    output logic [ADDRESS_BITS-1:0]        mem_req_address,
    output logic [DATA_WIDTH-1:0]          mem_req_data,
    input  logic                           mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]          mem_rsp_data,
    output logic                           busy
);

    localparam int PTR_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W      = OFFSET_BITS + 1;
    localparam int IDX_W      = (OFFSET_BITS > 0) ? OFFSET_BITS : 1;
    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int ALIGN_BITS = OFFSET_BITS + BYTE_SHIFT;
    localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK =
        ~((ADDRESS_BITS'(1) << ALIGN_BITS) - ADDRESS_BITS'(1));
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] ALL_WORDS = CNT_W'(WORDS);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESPOND} state_t;

    state_t                  state, state_next;
    logic [PTR_W-1:0]        rr, winner, pick, cand;
    logic                    found;
    int                      idx;
    logic                    is_write;
    logic [ADDRESS_BITS-1:0] base;
    logic [DATA_WIDTH-1:0]   words [WORDS];
    logic [CNT_W-1:0]        k, r, r_next;
    logic                    rsp_take;
    logic [ADDRESS_BITS-1:0] held_address;
    logic [LINE_W-1:0]       held_data, line_flat;

    // Cyclic first-set search starting at the round-robin pointer.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        cand  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(rr) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            cand = PTR_W'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign rsp_take = !is_write && (state == ISSUE || state == WAIT_RD)
                      && mem_rsp_valid && (r < ALL_WORDS);
    assign r_next   = r + CNT_W'(rsp_take);

    always_comb begin
        line_flat = '0;
        for (int i = 0; i < WORDS; i++) line_flat[i*DATA_WIDTH +: DATA_WIDTH] = words[i];
    end

    always_comb begin
        state_next    = state;
        req_ready     = '0;
        rsp_valid     = '0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready  = NUM_PORTS'(1) << pick;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                mem_req_write = is_write;
                if (mem_req_ready && k == LAST_WORD)
                    state_next = (is_write || r_next == ALL_WORDS) ? RESPOND : WAIT_RD;
            end
            WAIT_RD: begin
                if (r_next == ALL_WORDS) state_next = RESPOND;
            end
            RESPOND: begin
                rsp_valid  = NUM_PORTS'(1) << winner;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy            = (state != IDLE);
    assign mem_req_address = base + (ADDRESS_BITS'(k) << BYTE_SHIFT);
    assign mem_req_data    = words[IDX_W'(k)];
    // Outside the response pulse the last completed line stays visible.
    assign rsp_address     = (state == RESPOND) ? base : held_address;
    assign rsp_data        = (state == RESPOND) ? line_flat : held_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr           <= '0;
            winner       <= '0;
            is_write     <= 1'b0;
            base         <= '0;
            k            <= '0;
            r            <= '0;
            held_address <= '0;
            held_data    <= '0;
            for (int i = 0; i < WORDS; i++) words[i] <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (found) begin
                        winner   <= pick;
                        rr       <= (pick == PTR_W'(NUM_PORTS - 1)) ? '0 : pick + PTR_W'(1);
                        is_write <= req_write[pick];
                        base     <= req_address[int'(pick)*ADDRESS_BITS +: ADDRESS_BITS] & ALIGN_MASK;
                        k        <= '0;
                        r        <= '0;
                        for (int i = 0; i < WORDS; i++)
                            words[i] <= req_data[int'(pick)*LINE_W + i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) k <= k + CNT_W'(1);
                end
                RESPOND: begin
                    held_address <= base;
                    held_data    <= line_flat;
                end
                default: ;
            endcase
            if (rsp_take) begin
                words[IDX_W'(r)] <= mem_rsp_data;
                r                <= r_next;
            end
        end
    end

endmodule

// File: tb/tb_line_burst_arbiter.sv
// Directed bench for line_burst_arbiter: reads, stalled writes, round-robin,
// late read returns and reset abort, with hand-computed expectations.
module tb_line_burst_arbiter;

    localparam int NP = 2;
    localparam int DW = 32;
    localparam int AB = 32;
    localparam int LW = 128;

    logic             clock;
    logic             reset;
    logic [NP-1:0]    req_valid, req_ready, req_write, rsp_valid;
    logic [NP*AB-1:0] req_address;
    logic [NP*LW-1:0] req_data;
    logic [AB-1:0]    rsp_address;
    logic [LW-1:0]    rsp_data;
    logic             mem_req_valid, mem_req_ready, mem_req_write;
    logic [AB-1:0]    mem_req_address;
    logic [DW-1:0]    mem_req_data;
    logic             mem_rsp_valid;
    logic [DW-1:0]    mem_rsp_data;
    logic             busy;

    logic             auto_mem;
    logic [DW-1:0]    auto_base;
    logic             auto_rsp_valid;
    logic [DW-1:0]    auto_rsp_data;
    logic             man_rsp_valid;
    logic [DW-1:0]    man_rsp_data;

    int total = 0;
    int bad   = 0;

    assign mem_rsp_valid = auto_mem ? auto_rsp_valid : man_rsp_valid;
    assign mem_rsp_data  = auto_mem ? auto_rsp_data  : man_rsp_data;

    line_burst_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .OFFSET_BITS(2)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_address(rsp_address), .rsp_data(rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_address(mem_req_address),
        .mem_req_data(mem_req_data), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .busy(busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory model: each read request returns auto_base + word index one cycle later.
    initial begin
        logic          hs;
        logic [DW-1:0] d;
        auto_rsp_valid = 1'b0;
        auto_rsp_data  = '0;
        forever begin
            @(negedge clock);
            hs = (auto_mem === 1'b1) && mem_req_valid && mem_req_ready && !mem_req_write;
            d  = auto_base + DW'(mem_req_address[3:2]);
            @(posedge clock);
            #1;
            auto_rsp_valid = hs;
            auto_rsp_data  = hs ? d : '0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid     = '0;
        req_write     = '0;
        req_address   = '0;
        req_data      = '0;
        mem_req_ready = 1'b1;
        auto_mem      = 1'b0;
        man_rsp_valid = 1'b0;
        man_rsp_data  = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0h want=0", busy); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("[TB] FAIL reset_req_ready got=%0h want=0", req_ready); end
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("[TB] FAIL reset_rsp_valid got=%0h want=0", rsp_valid); end
        total++; if (mem_req_valid !== 1'b0 || mem_req_write !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_ctrl got=%0h%0h want=00", mem_req_valid, mem_req_write); end
        total++; if (mem_req_address !== 32'h0 || mem_req_data !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_fields got=%0h/%0h want=0/0", mem_req_address, mem_req_data); end
        total++; if (rsp_address !== 32'h0 || rsp_data !== 128'h0) begin bad++; $display("[TB] FAIL reset_rsp_fields got=%0h/%0h want=0/0", rsp_address, rsp_data); end
        tick();
        reset = 1'b0;
        @(negedge clock);
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_busy got=%0h want=0", busy); end
        tick();
    endtask

    task automatic test_read();
        int hs_n, pulse_n;
        hs_n = 0;
        pulse_n = 0;
        auto_mem  = 1'b1;
        auto_base = 32'hA0;
        mem_req_ready = 1'b1;
        req_valid = 2'b01;
        req_write = 2'b00;
        req_address[0 +: AB] = 32'h104;
        @(negedge clock);
        total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL read_grant got=%0h want=1", req_ready); end
        tick();
        req_valid = 2'b00;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (mem_req_valid && mem_req_ready) begin
                total++; if (mem_req_address !== 32'h100 + 32'(hs_n * 4)) begin bad++; $display("[TB] FAIL read_word_addr got=%0h want=%0h", mem_req_address, 32'h100 + 32'(hs_n * 4)); end
                hs_n++;
            end
            if (rsp_valid !== 2'b00) begin
                pulse_n++;
                total++; if (rsp_valid !== 2'b01) begin bad++; $display("[TB] FAIL read_rsp_valid got=%0h want=1", rsp_valid); end
                total++; if (rsp_address !== 32'h100) begin bad++; $display("[TB] FAIL read_rsp_addr got=%0h want=100", rsp_address); end
                total++; if (rsp_data !== 128'h000000A3_000000A2_000000A1_000000A0) begin bad++; $display("[TB] FAIL read_rsp_data got=%0h want=a3a2a1a0", rsp_data); end
            end
            tick();
        end
        total++; if (hs_n !== 4) begin bad++; $display("[TB] FAIL read_handshakes got=%0d want=4", hs_n); end
        total++; if (pulse_n !== 1) begin bad++; $display("[TB] FAIL read_pulses got=%0d want=1", pulse_n); end
        total++; if (rsp_data !== 128'h000000A3_000000A2_000000A1_000000A0) begin bad++; $display("[TB] FAIL read_data_hold got=%0h want=a3a2a1a0", rsp_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL read_idle_busy got=%0h want=0", busy); end
    endtask

    task automatic test_write_stall();
        int hs_n, pulse_n, stalls, w2_cycles;
        hs_n = 0;
        pulse_n = 0;
        stalls = 0;
        w2_cycles = 0;
        req_valid = 2'b10;
        req_write = 2'b10;
        req_address[AB +: AB] = 32'h200;
        req_data[LW +: LW] = 128'h00000044_00000033_00000022_00000011;
        @(negedge clock);
        total++; if (req_ready !== 2'b10) begin bad++; $display("[TB] FAIL write_grant got=%0h want=2", req_ready); end
        tick();
        req_valid = 2'b00;
        for (int c = 0; c < 20; c++) begin
            mem_req_ready = !(mem_req_valid && mem_req_address == 32'h208 && stalls < 2);
            @(negedge clock);
            if (mem_req_valid && mem_req_address == 32'h208) begin
                w2_cycles++;
                total++; if (mem_req_data !== 32'h33) begin bad++; $display("[TB] FAIL write_word2_stable got=%0h want=33", mem_req_data); end
            end
            if (mem_req_valid && !mem_req_ready) stalls++;
            if (mem_req_valid && mem_req_ready) begin
                total++; if (mem_req_write !== 1'b1) begin bad++; $display("[TB] FAIL write_flag got=%0h want=1", mem_req_write); end
                total++; if (mem_req_address !== 32'h200 + 32'(hs_n * 4) || mem_req_data !== 32'h11 * 32'(hs_n + 1)) begin bad++; $display("[TB] FAIL write_word got=%0h:%0h want=%0h:%0h", mem_req_address, mem_req_data, 32'h200 + 32'(hs_n * 4), 32'h11 * 32'(hs_n + 1)); end
                hs_n++;
            end
            if (rsp_valid !== 2'b00) begin
                pulse_n++;
                total++; if (rsp_valid !== 2'b10 || rsp_address !== 32'h200) begin bad++; $display("[TB] FAIL write_rsp got=%0h@%0h want=2@200", rsp_valid, rsp_address); end
                total++; if (rsp_data !== 128'h00000044_00000033_00000022_00000011) begin bad++; $display("[TB] FAIL write_rsp_data got=%0h want=44332211", rsp_data); end
            end
            tick();
        end
        mem_req_ready = 1'b1;
        total++; if (hs_n !== 4) begin bad++; $display("[TB] FAIL write_handshakes got=%0d want=4", hs_n); end
        total++; if (w2_cycles !== 3) begin bad++; $display("[TB] FAIL write_word2_cycles got=%0d want=3", w2_cycles); end
        total++; if (pulse_n !== 1) begin bad++; $display("[TB] FAIL write_pulses got=%0d want=1", pulse_n); end
    endtask

    task automatic test_back_to_back();
        logic [NP-1:0] grants [8];
        logic [NP-1:0] pulses [8];
        logic [NP-1:0] want;
        int g_n, p_n;
        g_n = 0;
        p_n = 0;
        apply_reset();
        auto_mem  = 1'b1;
        auto_base = 32'hC0;
        req_valid = 2'b11;
        req_write = 2'b00;
        req_address[0 +: AB]  = 32'h000;
        req_address[AB +: AB] = 32'h040;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (req_ready !== 2'b00 && g_n < 8) begin grants[g_n] = req_ready; g_n++; end
            if (rsp_valid !== 2'b00 && p_n < 8) begin pulses[p_n] = rsp_valid; p_n++; end
            tick();
        end
        req_valid = 2'b00;
        total++; if (g_n < 4 || p_n < 4) begin bad++; $display("[TB] FAIL rr_event_count got=%0d/%0d want>=4/4", g_n, p_n); end
        for (int i = 0; i < 4 && i < g_n && i < p_n; i++) begin
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            total++; if (grants[i] !== want) begin bad++; $display("[TB] FAIL rr_grant%0d got=%0h want=%0h", i, grants[i], want); end
            total++; if (pulses[i] !== want) begin bad++; $display("[TB] FAIL rr_pulse%0d got=%0h want=%0h", i, pulses[i], want); end
        end
    endtask

    task automatic test_delayed_read();
        int hs_n, early;
        hs_n = 0;
        early = 0;
        apply_reset();
        man_rsp_valid = 1'b1;
        man_rsp_data  = 32'hDEADBEEF;
        tick();
        tick();
        @(negedge clock);
        total++; if (busy !== 1'b0 || mem_req_valid !== 1'b0 || rsp_valid !== 2'b00) begin bad++; $display("[TB] FAIL spurious_idle got=%0h%0h%0h want=000", busy, mem_req_valid, rsp_valid); end
        tick();
        man_rsp_valid = 1'b0;
        req_valid = 2'b01;
        req_write = 2'b00;
        req_address[0 +: AB] = 32'h300;
        @(negedge clock);
        total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL late_grant got=%0h want=1", req_ready); end
        tick();
        req_valid = 2'b00;
        for (int c = 0; c < 10 && hs_n < 4; c++) begin
            @(negedge clock);
            if (mem_req_valid && mem_req_ready) hs_n++;
            tick();
        end
        total++; if (hs_n !== 4) begin bad++; $display("[TB] FAIL late_handshakes got=%0d want=4", hs_n); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (rsp_valid !== 2'b00 || busy !== 1'b1) early++;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            man_rsp_valid = 1'b1;
            man_rsp_data  = 32'hB0 + 32'(i);
            @(negedge clock);
            if (rsp_valid !== 2'b00) early++;
            tick();
        end
        man_rsp_valid = 1'b1;
        man_rsp_data  = 32'hFF;
        total++; if (early !== 0) begin bad++; $display("[TB] FAIL late_early_rsp got=%0d want=0", early); end
        @(negedge clock);
        total++; if (rsp_valid !== 2'b01 || rsp_address !== 32'h300) begin bad++; $display("[TB] FAIL late_rsp got=%0h@%0h want=1@300", rsp_valid, rsp_address); end
        total++; if (rsp_data !== 128'h000000B3_000000B2_000000B1_000000B0) begin bad++; $display("[TB] FAIL late_rsp_data got=%0h want=b3b2b1b0", rsp_data); end
        tick();
        man_rsp_valid = 1'b0;
        @(negedge clock);
        total++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin bad++; $display("[TB] FAIL late_after got=%0h/%0h want=0/0", rsp_valid, busy); end
        total++; if (rsp_data !== 128'h000000B3_000000B2_000000B1_000000B0) begin bad++; $display("[TB] FAIL late_hold got=%0h want=b3b2b1b0", rsp_data); end
        tick();
    endtask

    task automatic test_reset_abort();
        int pulse_n;
        logic [NP-1:0] seen;
        pulse_n = 0;
        seen = '0;
        apply_reset();
        req_valid = 2'b01;
        req_write = 2'b01;
        req_address[0 +: AB] = 32'h400;
        req_data[0 +: LW] = 128'h4444_3333_2222_1111_0000_0000_0000_5555;
        tick();
        req_valid = 2'b00;
        @(negedge clock);
        total++; if (mem_req_address !== 32'h400) begin bad++; $display("[TB] FAIL abort_word0 got=%0h want=400", mem_req_address); end
        tick();
        @(negedge clock);
        total++; if (mem_req_address !== 32'h404) begin bad++; $display("[TB] FAIL abort_word1 got=%0h want=404", mem_req_address); end
        tick();
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_write !== 1'b0) begin bad++; $display("[TB] FAIL abort_ctrl got=%0h%0h%0h want=000", busy, mem_req_valid, mem_req_write); end
        total++; if (mem_req_address !== 32'h0 || mem_req_data !== 32'h0) begin bad++; $display("[TB] FAIL abort_fields got=%0h/%0h want=0/0", mem_req_address, mem_req_data); end
        total++; if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin bad++; $display("[TB] FAIL abort_handshake got=%0h/%0h want=0/0", rsp_valid, req_ready); end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (rsp_valid !== 2'b00) pulse_n++;
            tick();
        end
        total++; if (pulse_n !== 0) begin bad++; $display("[TB] FAIL abort_no_rsp got=%0d want=0", pulse_n); end
        req_valid = 2'b10;
        req_write = 2'b10;
        req_address[AB +: AB] = 32'h500;
        req_data[LW +: LW] = 128'h1;
        @(negedge clock);
        total++; if (req_ready !== 2'b10) begin bad++; $display("[TB] FAIL abort_port1_grant got=%0h want=2", req_ready); end
        tick();
        req_valid = 2'b00;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (rsp_valid !== 2'b00) begin pulse_n++; seen = rsp_valid; end
            tick();
        end
        total++; if (pulse_n !== 1 || seen !== 2'b10) begin bad++; $display("[TB] FAIL abort_port1_rsp got=%0d:%0h want=1:2", pulse_n, seen); end
        req_valid = 2'b11;
        @(negedge clock);
        total++; if (req_ready !== 2'b01) begin bad++; $display("[TB] FAIL abort_rr_wrap got=%0h want=1", req_ready); end
        tick();
        req_valid = 2'b00;
    endtask

    initial begin
        reset = 1'b0;
        auto_base = '0;
        idle_inputs();
        #1;
        test_reset();
        test_read();
        test_write_stall();
        test_back_to_back();
        test_delayed_read();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_burst_arbiter.md
LINE_BURST_ARBITER -- requirements
Module: line_burst_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2, is the number of cache-side requesters (1..16).
REQ-002 Parameter DATA_WIDTH, default 32, is the main-memory word width in bits (multiple of 8).
REQ-003 Parameter ADDRESS_BITS, default 32, is the byte-address width.
REQ-004 Parameter OFFSET_BITS, default 2, sets words per line: WORDS = 2^OFFSET_BITS, LINE_W = DATA_WIDTH*WORDS.
REQ-005 clock  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  NUM_PORTS  per-port line request pending.
REQ-008 req_ready  out  NUM_PORTS  per-port acceptance; at most one bit set.
REQ-009 req_write  in  NUM_PORTS  1 = line write, 0 = line read.
REQ-010 req_address  in  NUM_PORTS*ADDRESS_BITS  per-port byte address (port i at [i*ADDRESS_BITS +: ADDRESS_BITS]).
REQ-011 req_data  in  NUM_PORTS*LINE_W  per-port write line.
REQ-012 rsp_valid  out  NUM_PORTS  one-hot, one-cycle completion pulse.
REQ-013 rsp_address  out  ADDRESS_BITS  aligned line address of the completing transaction.
REQ-014 rsp_data  out  LINE_W  read line (reads) or written line (writes).
REQ-015 mem_req_valid / mem_req_ready  out / in  1 / 1  word request handshake to main memory.
REQ-016 mem_req_write, mem_req_address, mem_req_data  out  1, ADDRESS_BITS, DATA_WIDTH  word request fields.
REQ-017 mem_rsp_valid, mem_rsp_data  in  1, DATA_WIDTH  in-order read-word return.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT_RD, RESPOND.
REQ-020 IDLE: if any req_valid, the winner is the first set bit searched cyclically from pointer rr; req_ready[winner]=1 combinationally that cycle; the transaction is captured and the FSM goes to ISSUE.
REQ-021 After each grant rr SHALL become (winner+1) mod NUM_PORTS; reset value 0.
REQ-022 Captured address SHALL be aligned by clearing its low OFFSET_BITS+log2(DATA_WIDTH/8) bits.
REQ-023 ISSUE: mem_req_valid=1 presenting word k at base + k*(DATA_WIDTH/8), data = line[k*DATA_WIDTH +: DATA_WIDTH] for writes; k increments only when mem_req_valid and mem_req_ready are both high.
REQ-024 After the handshake of word WORDS-1: write goes to RESPOND; read goes to RESPOND if all WORDS returns are already counted, else WAIT_RD.
REQ-025 During read transactions (ISSUE and WAIT_RD) each mem_rsp_valid SHALL store mem_rsp_data into word slot r and increment r; a return and a request handshake in the same cycle are both counted.
REQ-026 WAIT_RD goes to RESPOND in the cycle after the WORDS-th return is stored.
REQ-027 RESPOND: rsp_valid[winner]=1 for exactly one cycle with rsp_address and rsp_data valid, then IDLE; no grant issued in RESPOND.
REQ-028 mem_rsp_valid in IDLE, RESPOND, write transactions, or beyond WORDS returns SHALL be ignored.
REQ-029 req_ready SHALL be 0 outside IDLE; requesters hold req_* stable until granted.
REQ-030 With NUM_PORTS=1, port 0 wins every grant.
REQ-031 rsp_address and rsp_data SHALL hold their last values between pulses.

Reset
REQ-032 Reset SHALL asynchronously force IDLE, rr=0, k=0, r=0, and req_ready, rsp_valid, mem_req_valid, mem_req_write, busy to 0; rsp_address, rsp_data, mem_req_address, mem_req_data to 0.
REQ-033 A transaction aborted by reset SHALL produce no rsp_valid pulse; post-reset behaviour equals power-up.

Verification
REQ-034 Read, port 0, address 0x104, mem_req_ready=1, returns 1 cycle after each request with data 0xA0..0xA3 -> words requested at 0x100,0x104,0x108,0x10C; rsp_valid=01, rsp_address=0x100, rsp_data=0xA3_A2_A1_A0 (word 0 at LSBs).
REQ-035 Write, port 1, address 0x200, line 0x44_33_22_11, mem_req_ready low for 2 cycles on word 2 -> word 2 held stable 3 cycles, 4 write handshakes, rsp_valid=10.
REQ-036 Both ports requesting continuously from reset -> grants 0,1,0,1; rsp_valid pulses alternate 01,10.
REQ-037 Read with all 4 returns arriving in WAIT_RD after a 10-cycle gap -> RESPOND exactly one cycle after the 4th return; spurious mem_rsp_valid in IDLE changes nothing.
REQ-038 Reset asserted in ISSUE after word 1 -> all outputs 0 immediately, no rsp_valid; next request from port 1 alone is granted with rr=0.
